mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port memory DUT between NUM_REQ requesters.
- Each requester presents a read or write command with a req/gnt handshake.
- The arbiter sequences exactly one memory access at a time and returns read data with a per-requester rvalid pulse.
- Sits between the requester agents and the memory port of mem_if.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- DEPTH, 256, number of valid memory words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until gnt is seen.
- we  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  packed per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed per-requester write data.
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse.
- err  out  NUM_REQ  one-cycle pulse, coincident with gnt, flags an out-of-range address.
- rdata  out  DATA_W  read data; meaningful only while any rvalid is high.
- busy  out  1  high in every state except IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset: all outputs are registered and 0 during reset (gnt, rvalid, err, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata). Round-robin pointer = 0. State = IDLE.
- Reset mid-operation: any in-flight access is abandoned and no rvalid is issued for it.
- States: IDLE, CMD, ERR, RD_WAIT, RD_RESP.
- Arbitration happens only in IDLE, on cycle T where req != 0.
  - Winner = first asserted req scanning from pointer upward, wrapping at NUM_REQ.
  - Pointer <= (winner+1) mod NUM_REQ. The pointer advances on error grants too.
  - Winner's we/addr/wdata are captured at the T edge.
  - Next state is CMD if the captured addr < DEPTH, otherwise ERR.
- CMD (cycle T+1):
  - gnt[w]=1 and mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven from the captured command.
  - Write: next state IDLE.
  - Read: next state RD_WAIT.
- ERR (T+1): gnt[w]=1, err[w]=1, mem_en=0, then next state IDLE. Memory is untouched.
- RD_WAIT (T+2): mem_en=0. mem_rdata is registered at the end of this cycle.
- RD_RESP (T+3): rvalid[w]=1 and rdata = captured word, then next state IDLE.
- Latency from req seen in IDLE:
  - gnt at +1 cycle.
  - Read rvalid at +3 cycles.
  - Minimum spacing between accepted commands: 2 cycles (write/err) or 4 cycles (read).
- Requester rules:
  - Keep req, we, addr and wdata stable until the cycle gnt is seen.
  - Drop req, or present a new command, on the cycle after gnt.
  - Because arbitration is blocked in CMD/ERR, a req still high during the gnt cycle is not re-granted for that command.
- Outside the active state, mem_en, gnt, rvalid and err are 0. mem_addr and mem_wdata hold their last values.
- A req that falls before being granted is simply not considered (no error).
- Simultaneous requests are resolved purely by the pointer. No requester waits more than NUM_REQ-1 grants.
- The arbiter adds no arithmetic beyond the pointer increment (modulo NUM_REQ) and the address compare against DEPTH.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum arb_state_e {IDLE, CMD, ERR, RD_WAIT, RD_RESP};
  - default width constants;
  - a function computing the next pointer.
- One sub-module, rr_arbiter:
  - parameterised by NUM_REQ;
  - combinational pick from req and pointer, outputting a one-hot winner and its index;
  - registered pointer update driven by an advance strobe.
- mem_arbiter holds the FSM, command capture and memory-port registers.

Test Plan:
- Single write then read: req[1] writes 0xA5 to addr 0x10, then reads addr 0x10.
  - gnt[1] at +1.
  - mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 during the write gnt cycle.
  - rvalid[1] with rdata=0xA5 at +3 after the read req.
- Round-robin: all four req held high with writes, starting from reset.
  - gnt order is 0,1,2,3,0, with each gnt 2 cycles apart.
- Fairness after wrap: pointer=3, req=4'b1001.
  - gnt[3] first, then gnt[0].
  - Then with req=4'b1001 again: gnt[0] precedes gnt[3] is wrong. The next grant must be gnt[0] only if pointer=0; check the pointer sequence 3,0,1.
- Out of range: DEPTH=200 override, req[2] reads addr 0xC8.
  - gnt[2] and err[2] together at +1.
  - mem_en stays 0; no rvalid[2].
  - A following read to 0xC7 succeeds.
- Reset mid-read: assert rst low during RD_WAIT.
  - All outputs are 0 immediately (asynchronously).
  - After release, no rvalid appears; the pointer is 0 and the next grant goes to the lowest asserted req.
- Back-to-back reads by req[0] and req[3] with different addresses.
  - Each rvalid carries the correct data.
  - rvalid[0] and rvalid[3] are never high together.
  - Spacing between successive rvalids is 4 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, default widths and the round-robin pointer step.
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ERR, RD_WAIT, RD_RESP} arb_state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 256;
  function automatic int next_ptr(input int cur, input int n);
    return (cur + 1 == n) ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or above the pointer, wrapping; pointer steps past the winner on advance.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PW = $clog2(NUM_REQ)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      idx_o
);
  logic [PW-1:0] ptr_q;
  // lowest request overall, overridden by the lowest at or above the pointer
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (req_i[k]) idx_o = PW'(k);
    for (int k = NUM_REQ - 1; k >= 0; k--) if (req_i[k] && k >= int'(ptr_q)) idx_o = PW'(k);
  end
  assign grant_o = |req_i ? (NUM_REQ'(1) << idx_o) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else if (advance_i) ptr_q <= PW'(next_ptr(int'(idx_o), NUM_REQ));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory, one access at a time,
// with registered handshake, error and read-return outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant, gnt_q, rvalid_q, err_q;
  logic [PW-1:0] idx, w_q;
  logic [ADDR_W-1:0] sel_addr, mem_addr_q;
  logic [DATA_W-1:0] sel_wdata, mem_wdata_q, rdata_q;
  logic take, in_range, we_q, busy_q, mem_en_q, mem_we_q;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk), .rst(rst), .req_i(req), .advance_i(take), .grant_o(grant), .idx_o(idx)
  );
  assign sel_addr = addr[int'(idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(idx)*DATA_W +: DATA_W];
  assign in_range = {1'b0, sel_addr} < DEPTH_L;
  assign take = (state_q == IDLE) && |req;
  always_comb begin
    state_d = state_q == IDLE ? (take ? (in_range ? CMD : ERR) : IDLE) :
              (state_q == CMD && !we_q) ? RD_WAIT :
              state_q == RD_WAIT ? RD_RESP : IDLE;
  end
  // every output is a register loaded from the state it will accompany
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      err_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      w_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= take ? grant : '0;
      err_q <= (take && !in_range) ? grant : '0;
      mem_en_q <= take && in_range;
      mem_we_q <= take && in_range && we[idx];
      rvalid_q <= state_q == RD_WAIT ? (NUM_REQ'(1) << w_q) : '0;
      busy_q <= state_d != IDLE;
      if (take) begin
        w_q <= idx;
        we_q <= we[idx];
      end
      if (take && in_range) begin
        mem_addr_q <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      if (state_q == RD_WAIT) rdata_q <= mem_rdata;
    end
  assign gnt = gnt_q;
  assign err = err_q;
  assign rvalid = rvalid_q;
  assign rdata = rdata_q;
  assign busy = busy_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule
